// File: rtl/vend_ctrl.sv
// Vending transaction controller: coin credit, gated dispense strobe to the can counter, change return.
// Latency: accepted vend_req -> dispense 1 cycle (load low); dispense -> change_valid 2 cycles.
// Backpressure: change_ready stalls CHANGE with change_amount held; load stalls VEND. Optional VEND_TIMEOUT_EN adds an idle refund.
module vend_ctrl #(
   parameter int PRICE       = 75,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_valid,
   input  logic [1:0] coin_value,
   input  logic       vend_req,
   input  logic       cancel,
   input  logic       empty,
   input  logic       load,
   output logic       dispense,
   output logic       coin_reject,
   output logic       change_valid,
   output logic [7:0] change_amount,
   input  logic       change_ready,
   output logic [7:0] credit,
   output logic       sold_out
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      VEND    = 3'd2,
      SETTLE  = 3'd3,
      CHANGE  = 3'd4
   } state_t;

   localparam logic [7:0] PRICE_8 = 8'(PRICE);

   state_t     state_q, state_d;
   logic [7:0] credit_q, credit_d;
   logic       coin_reject_q, coin_reject_d;
   logic       change_valid_q, change_valid_d;
   logic [7:0] change_amount_q, change_amount_d;
   logic       sold_out_q, sold_out_d;

   logic [7:0] coin_cents;
   logic [8:0] coin_sum;
   logic [7:0] remainder;
   logic       vend_ok;
   logic       timeout_hit;

   // Coin code to cents; the 9-bit sum lets an overflowing coin be refused instead of wrapping.
   always_comb begin
      coin_cents = 8'd5;
      case (coin_value)
         2'b00: coin_cents = 8'd5;
         2'b01: coin_cents = 8'd10;
         2'b10: coin_cents = 8'd25;
         2'b11: coin_cents = 8'd100;
         default: coin_cents = 8'd5;
      endcase
      coin_sum  = {1'b0, credit_q} + {1'b0, coin_cents};
      remainder = credit_q - PRICE_8;
      // Evaluated on pre-coin credit and on the registered empty flag.
      vend_ok   = vend_req && (credit_q >= PRICE_8) && !sold_out_q && !load;
   end

`ifdef VEND_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] idle_cnt_q, idle_cnt_d;

   // Inactivity counter: runs only in COLLECT, cleared by any coin or vend request.
   always_comb begin
      idle_cnt_d  = '0;
      timeout_hit = 1'b0;
      if (state_q == COLLECT && !coin_valid && !vend_req) begin
         if (idle_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            timeout_hit = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + TW'(1);
         end
      end
   end

   // Inactivity counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state and next-output logic for the transaction FSM.
   always_comb begin
      state_d         = state_q;
      credit_d        = credit_q;
      coin_reject_d   = 1'b0;
      change_valid_d  = change_valid_q;
      change_amount_d = change_amount_q;
      sold_out_d      = empty;

      case (state_q)
         IDLE, COLLECT: begin
            if (coin_valid) begin
               if (!coin_sum[8]) begin
                  credit_d = coin_sum[7:0];
                  state_d  = COLLECT;
               end else begin
                  coin_reject_d = 1'b1;
               end
            end
            // With zero credit in IDLE a cancel or vend has nothing to act on.
            if (state_q == COLLECT) begin
               if (cancel || timeout_hit) begin
                  // Refund includes a coin accepted in this same cycle.
                  state_d         = CHANGE;
                  change_valid_d  = 1'b1;
                  change_amount_d = credit_d;
               end else if (vend_ok) begin
                  state_d = VEND;
               end
            end
         end
         VEND: begin
            coin_reject_d = coin_valid;
            // Hold off while the counter is being loaded so the strobe is never lost.
            if (!load) begin
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            coin_reject_d = coin_valid;
            credit_d      = remainder;
            if (remainder != 8'd0) begin
               state_d         = CHANGE;
               change_valid_d  = 1'b1;
               change_amount_d = remainder;
            end else begin
               state_d = IDLE;
            end
         end
         CHANGE: begin
            coin_reject_d = coin_valid;
            if (change_valid_q && change_ready) begin
               credit_d       = 8'd0;
               change_valid_d = 1'b0;
               state_d        = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset discards credit and any pending change.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         credit_q        <= 8'd0;
         coin_reject_q   <= 1'b0;
         change_valid_q  <= 1'b0;
         change_amount_q <= 8'd0;
         sold_out_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         credit_q        <= credit_d;
         coin_reject_q   <= coin_reject_d;
         change_valid_q  <= change_valid_d;
         change_amount_q <= change_amount_d;
         sold_out_q      <= sold_out_d;
      end
   end

   // Dispense is combinational from state so it drops in the same cycle load rises.
   assign dispense      = (state_q == VEND) && !load;
   assign coin_reject   = coin_reject_q;
   assign change_valid  = change_valid_q;
   assign change_amount = change_amount_q;
   assign credit        = credit_q;
   assign sold_out      = sold_out_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl with PRICE=75 and TIMEOUT_CYC=8.
// Inputs change 1 ns after the rising edge; outputs are checked at that same point.
// The idle-refund step is compiled in only when VEND_TIMEOUT_EN is defined.
module tb_vend_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       coin_valid;
   logic [1:0] coin_value;
   logic       vend_req;
   logic       cancel;
   logic       empty;
   logic       load;
   logic       dispense;
   logic       coin_reject;
   logic       change_valid;
   logic [7:0] change_amount;
   logic       change_ready;
   logic [7:0] credit;
   logic       sold_out;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [1:0] C5 = 2'b00, C10 = 2'b01, C25 = 2'b10, C100 = 2'b11;

   vend_ctrl #(.PRICE(75), .TIMEOUT_CYC(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .coin_valid    (coin_valid),
      .coin_value    (coin_value),
      .vend_req      (vend_req),
      .cancel        (cancel),
      .empty         (empty),
      .load          (load),
      .dispense      (dispense),
      .coin_reject   (coin_reject),
      .change_valid  (change_valid),
      .change_amount (change_amount),
      .change_ready  (change_ready),
      .credit        (credit),
      .sold_out      (sold_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic coin(input logic [1:0] code);
      coin_valid = 1'b1;
      coin_value = code;
      tick();
      coin_valid = 1'b0;
   endtask

   task automatic pulse_vend();
      vend_req = 1'b1;
      tick();
      vend_req = 1'b0;
   endtask

   task automatic pulse_cancel();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
   endtask

   initial begin
      reset = 1'b1; coin_valid = 1'b0; coin_value = C5; vend_req = 1'b0;
      cancel = 1'b0; empty = 1'b0; load = 1'b0; change_ready = 1'b1;
      tick(); tick();
      chk("rst_credit", credit, 0);
      chk("rst_dispense", dispense, 0);
      chk("rst_reject", coin_reject, 0);
      chk("rst_cvalid", change_valid, 0);
      chk("rst_camount", change_amount, 0);
      chk("rst_soldout", sold_out, 0);
      reset = 1'b0;
      tick();

      // Exact payment: 25+25+25 then vend, no change.
      coin(C25); coin(C25); coin(C25);
      chk("exact_credit", credit, 75);
      pulse_vend();
      chk("exact_disp_on", dispense, 1);
      tick();
      chk("exact_disp_off", dispense, 0);
      tick();
      chk("exact_credit0", credit, 0);
      chk("exact_nochange", change_valid, 0);
      tick();
      chk("exact_idle_disp", dispense, 0);

      // Overpay with 100, change 25 held under backpressure.
      change_ready = 1'b0;
      coin(C100);
      chk("over_credit", credit, 100);
      pulse_vend();
      chk("over_disp", dispense, 1);
      tick();
      chk("over_cv_lat1", change_valid, 0);
      tick();
      chk("over_cv", change_valid, 1);
      chk("over_amt", change_amount, 25);
      chk("over_credit_rem", credit, 25);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("over_hold_cv", change_valid, 1);
         chk("over_hold_amt", change_amount, 25);
      end
      change_ready = 1'b1;
      tick();
      chk("over_done_cv", change_valid, 0);
      chk("over_done_credit", credit, 0);

      // Sold out: vend ignored, cancel refunds full credit.
      empty = 1'b1;
      tick();
      chk("so_flag", sold_out, 1);
      coin(C100);
      pulse_vend();
      chk("so_nodisp", dispense, 0);
      chk("so_credit", credit, 100);
      tick();
      chk("so_nodisp2", dispense, 0);
      change_ready = 1'b0;
      pulse_cancel();
      chk("so_cv", change_valid, 1);
      chk("so_amt", change_amount, 100);
      change_ready = 1'b1;
      tick();
      chk("so_done_cv", change_valid, 0);
      chk("so_done_credit", credit, 0);
      empty = 1'b0;
      tick();
      chk("so_clear", sold_out, 0);

      // Insufficient credit, coin+vend judged on pre-coin credit, then vend stalled by load.
      coin(C25); coin(C25);
      pulse_vend();
      chk("low_nodisp", dispense, 0);
      chk("low_credit", credit, 50);
      coin_valid = 1'b1; coin_value = C25; vend_req = 1'b1;
      tick();
      coin_valid = 1'b0; vend_req = 1'b0;
      chk("cv_same_credit", credit, 75);
      chk("cv_same_nodisp", dispense, 0);
      pulse_vend();
      load = 1'b1;
      #1;
      chk("load_disp0", dispense, 0);
      tick();
      chk("load_disp1", dispense, 0);
      tick();
      chk("load_disp2", dispense, 0);
      load = 1'b0;
      #1;
      chk("load_release_disp", dispense, 1);
      tick();
      chk("load_single_pulse", dispense, 0);
      tick();
      chk("load_credit0", credit, 0);
      chk("load_nochange", change_valid, 0);

      // Credit ceiling: 255 accepted, anything beyond rejected.
      coin(C100); coin(C100);
      chk("cap_credit200", credit, 200);
      coin(C100);
      chk("cap_reject", coin_reject, 1);
      chk("cap_keep200", credit, 200);
      tick();
      chk("cap_reject_clr", coin_reject, 0);
      coin(C25); coin(C25); coin(C5);
      chk("cap_255", credit, 255);
      chk("cap_255_noreject", coin_reject, 0);
      coin(C5);
      chk("cap_reject5", coin_reject, 1);
      chk("cap_keep255", credit, 255);

      // Cancel beats vend; coin during CHANGE is rejected.
      change_ready = 1'b0;
      cancel = 1'b1; vend_req = 1'b1;
      tick();
      cancel = 1'b0; vend_req = 1'b0;
      chk("cxl_nodisp", dispense, 0);
      chk("cxl_cv", change_valid, 1);
      chk("cxl_amt", change_amount, 255);
      coin(C10);
      chk("chg_coin_reject", coin_reject, 1);
      chk("chg_credit", credit, 255);
      chk("chg_amt_hold", change_amount, 255);
      change_ready = 1'b1;
      tick();
      chk("cxl_done_credit", credit, 0);

      // Reset during CHANGE discards everything.
      change_ready = 1'b0;
      coin(C100);
      pulse_vend();
      tick(); tick();
      chk("rstmid_cv", change_valid, 1);
      chk("rstmid_amt", change_amount, 25);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rstmid_cv0", change_valid, 0);
      chk("rstmid_credit0", credit, 0);
      coin(C5);
      chk("rstmid_fresh", credit, 5);
      pulse_cancel();
      chk("rstmid_refund", change_amount, 5);
      change_ready = 1'b1;
      tick();

`ifdef VEND_TIMEOUT_EN
      // Idle refund after 8 quiet cycles in COLLECT.
      change_ready = 1'b0;
      coin(C10);
      for (int i = 0; i < 7; i++) tick();
      chk("to_not_yet", change_valid, 0);
      tick();
      chk("to_cv", change_valid, 1);
      chk("to_amt", change_amount, 10);
      change_ready = 1'b1;
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
